cpu7_ifu_imem_rsp: RTL and testbench
====================================

CPU7_IFU_IMEM_RSP -- requirements
Module: cpu7_ifu_imem_rsp

Interface
REQ-001 SHALL have parameter AW, default 10, meaning log2 of instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter LAT, default 2, legal 1..4, meaning fixed cycles from address acceptance to inst_valid.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port inst_req, input, 1, fetch request valid.
REQ-006 SHALL have port inst_addr, input, 32, fetch byte address.
REQ-007 SHALL have port inst_cancel, input, 1, flush of all in-flight fetches.
REQ-008 SHALL have port mem_busy, input, 1, bench/bus stall; blocks acceptance.
REQ-009 SHALL have port wr_en, input, 1, memory load strobe.
REQ-010 SHALL have port wr_addr, input, AW, memory load word index.
REQ-011 SHALL have port wr_data, input, 32, memory load data.
REQ-012 SHALL have port inst_addr_ok, output, 1, request accepted this cycle.
REQ-013 SHALL have port inst_valid, output, 1, response valid.
REQ-014 SHALL have port inst_rdata, output, 128, up to four instruction words.
REQ-015 SHALL have port inst_count, output, 2, number of valid words in inst_rdata minus one.
REQ-016 SHALL have port inst_ex, output, 1, fetch exception flag.
REQ-017 SHALL have port inst_exccode, output, 6, exception code.
REQ-018 SHALL have port inst_uncache, output, 1, response address lies in uncached window.

Function
REQ-019 SHALL drive inst_addr_ok = inst_req & ~inst_cancel & ~mem_busy & resetn, combinationally.
REQ-020 SHALL capture on acceptance: memory read, exception, count, uncache bits, into stage 1 of an LAT-deep valid/data shift pipeline; inst_valid/outputs come from stage LAT.
REQ-021 SHALL return inst_valid exactly LAT cycles after the accepting cycle; back-to-back acceptances yield back-to-back responses, in order, up to LAT outstanding.
REQ-022 SHALL read words W = inst_addr[AW+1:2] .. W+inst_count; inst_rdata[32k+31:32k] = mem[W+k]; unused lanes SHALL be 0.
REQ-023 SHALL set inst_count = 3 - inst_addr[3:2] (never crosses a 16-byte block); word index SHALL not wrap past 2^AW-1 because blocks are aligned.
REQ-024 SHALL flag inst_ex=1, exccode 6'h08 (ADEF) when inst_addr[1:0] != 0; rdata=0, count=0.
REQ-025 SHALL flag inst_ex=1, exccode 6'h09 when inst_addr[31:AW+2] != 0 and not misaligned; misaligned takes priority; rdata=0, count=0.
REQ-026 SHALL drive inst_ex=0, inst_exccode=0 for non-faulting responses.
REQ-027 SHALL set inst_uncache = (inst_addr[31:29] == 3'b101), captured at acceptance.
REQ-028 SHALL, when inst_cancel=1 in cycle t, force inst_valid=0 in cycle t, accept nothing in t, and clear every pipeline valid at end of t; no pre-cancel fetch ever responds.
REQ-029 SHALL accept a request in cycle t+1 after cancel normally; its response appears at t+1+LAT.
REQ-030 SHALL perform wr_en writes at clock edge; a read accepted in the same cycle to the same word SHALL return the old data.
REQ-031 SHALL hold all data outputs at 0 when inst_valid=0.

Reset
REQ-032 SHALL, while resetn=0 at an edge, clear all pipeline valids; inst_addr_ok=0 combinationally while resetn=0.
REQ-033 SHALL after reset drive inst_valid=0, inst_rdata=0, inst_count=0, inst_ex=0, inst_exccode=0, inst_uncache=0.
REQ-034 SHALL not reset memory contents; wr_en SHALL be honoured during reset.
REQ-035 SHALL discard in-flight fetches when reset asserts mid-operation; no response after release.

Verification
REQ-036 Load mem[0..3]=11,22,33,44; LAT=2; req 0x0 at t -> addr_ok at t, inst_valid at t+2, rdata={44,33,22,11}, count=3.
REQ-037 Req 0x8 then 0xC back-to-back -> valid at t+2 count=1 rdata[63:0]={44,33}; t+3 count=0 rdata[31:0]=44, upper lanes 0.
REQ-038 Req 0x2 -> ex=1, exccode=0x08; req 0x0001_0000 (AW=10) -> ex=1, exccode=0x09; req 0xA000_0000 -> uncache=1, ex=1 code 0x09.
REQ-039 Accept at t, t+1; cancel at t+1 -> addr_ok=0 at t+1, no inst_valid at t+1..t+3; req at t+2 -> valid at t+4.
REQ-040 mem_busy=1 with inst_req=1 -> addr_ok=0, no response; write mem[0]=55 same cycle as accept of 0x0 -> response 11, later fetch 55.
REQ-041 resetn=0 one cycle between accept and response -> no inst_valid ever; all outputs 0.

Source files
------------

// File: rtl/cpu7_ifu_imem_rsp.sv
// Instruction-fetch memory responder with a fixed-latency pipeline.
//
// Accepts a fetch byte address and returns the 16-byte-aligned instruction
// block slice from the requested word up to the end of the block. The
// response appears exactly LAT cycles after the address is accepted.
// Misaligned or out-of-range addresses return an exception and no data. A
// cancel discards every fetch in flight. Memory contents are loaded through
// a separate write port and are never reset.
//
// Ports:
//   clock, resetn      single clock; synchronous active-low reset
//   inst_req/addr      fetch request and byte address
//   inst_cancel        flush of all in-flight fetches
//   mem_busy           stall, blocks acceptance
//   wr_en/addr/data    memory load port (word indexed)
//   inst_addr_ok       request accepted this cycle
//   inst_valid         response valid
//   inst_rdata         up to four instruction words, lane k = word W+k
//   inst_count         number of valid words minus one
//   inst_ex/exccode    fetch exception and code
//   inst_uncache       response address lies in the uncached window
module cpu7_ifu_imem_rsp #(
    parameter int unsigned AW  = 10,  // log2 of memory depth in words
    parameter int unsigned LAT = 2    // acceptance-to-response latency, 1..4
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           inst_req,
    input  logic [31:0]    inst_addr,
    input  logic           inst_cancel,
    input  logic           mem_busy,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [31:0]    wr_data,
    output logic           inst_addr_ok,
    output logic           inst_valid,
    output logic [127:0]   inst_rdata,
    output logic [1:0]     inst_count,
    output logic           inst_ex,
    output logic [5:0]     inst_exccode,
    output logic           inst_uncache
);

    localparam logic [5:0] ExcAdef  = 6'h08;
    localparam logic [5:0] ExcRange = 6'h09;

    typedef struct packed {
        logic [127:0] rdata;
        logic [1:0]   count;
        logic         ex;
        logic [5:0]   exccode;
        logic         uncache;
    } rsp_t;

    logic [31:0]    mem [2**AW];
    logic [LAT-1:0] valid_q;
    rsp_t           pipe_q [LAT];
    rsp_t           rsp_d;
    rsp_t           rsp_out;

    logic           misalign;
    logic           out_of_range;
    logic [AW-1:0]  base;
    logic [1:0]     count;

    assign inst_addr_ok = inst_req & ~inst_cancel & ~mem_busy & resetn;

    // Build the response for the address presented this cycle. The memory
    // read here sees the pre-edge contents, so a same-cycle write to the
    // same word is not visible to this fetch.
    always_comb begin
        misalign     = inst_addr[1:0] != 2'b00;
        out_of_range = (inst_addr >> (AW + 2)) != 32'd0;
        base         = inst_addr[AW+1:2];
        count        = 2'd3 - inst_addr[3:2];
        rsp_d         = '0;
        rsp_d.uncache = inst_addr[31:29] == 3'b101;
        if (misalign) begin
            rsp_d.ex      = 1'b1;
            rsp_d.exccode = ExcAdef;
        end else if (out_of_range) begin
            rsp_d.ex      = 1'b1;
            rsp_d.exccode = ExcRange;
        end else begin
            rsp_d.count = count;
            // Lanes past count would leave the block; they stay zero.
            for (int k = 0; k < 4; k++) begin
                if (2'(k) <= count) begin
                    rsp_d.rdata[32*k +: 32] = mem[base + AW'(k)];
                end
            end
        end
    end

    // Memory load port; deliberately independent of reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || inst_cancel) begin
            valid_q <= '0;
        end else begin
            valid_q <= (valid_q << 1) | LAT'(inst_addr_ok);
        end
    end

    // Payload needs no reset: it is only observed when its valid bit is set.
    always_ff @(posedge clock) begin
        pipe_q[0] <= rsp_d;
        for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    // A cancel suppresses the response emerging in the same cycle.
    assign inst_valid = valid_q[LAT-1] & ~inst_cancel & resetn;
    assign rsp_out    = inst_valid ? pipe_q[LAT-1] : '0;

    assign inst_rdata   = rsp_out.rdata;
    assign inst_count   = rsp_out.count;
    assign inst_ex      = rsp_out.ex;
    assign inst_exccode = rsp_out.exccode;
    assign inst_uncache = rsp_out.uncache;

endmodule

// File: tb/tb_cpu7_ifu_imem_rsp.sv
module tb_cpu7_ifu_imem_rsp;

    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 2;

    logic           clock       = 1'b0;
    logic           resetn      = 1'b0;
    logic           inst_req    = 1'b0;
    logic [31:0]    inst_addr   = '0;
    logic           inst_cancel = 1'b0;
    logic           mem_busy    = 1'b0;
    logic           wr_en       = 1'b0;
    logic [AW-1:0]  wr_addr     = '0;
    logic [31:0]    wr_data     = '0;
    logic           inst_addr_ok;
    logic           inst_valid;
    logic [127:0]   inst_rdata;
    logic [1:0]     inst_count;
    logic           inst_ex;
    logic [5:0]     inst_exccode;
    logic           inst_uncache;

    cpu7_ifu_imem_rsp #(
        .AW  (AW),
        .LAT (LAT)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_cancel  (inst_cancel),
        .mem_busy     (mem_busy),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .inst_addr_ok (inst_addr_ok),
        .inst_valid   (inst_valid),
        .inst_rdata   (inst_rdata),
        .inst_count   (inst_count),
        .inst_ex      (inst_ex),
        .inst_exccode (inst_exccode),
        .inst_uncache (inst_uncache)
    );

    typedef struct {
        int           cyc;
        logic [127:0] rdata;
        logic [1:0]   count;
        logic         ex;
        logic [5:0]   code;
        logic         unc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    logic [AW-1:0] load_addr [8] = '{10'd0, 10'd1, 10'd2, 10'd3,
                                     10'd1020, 10'd1021, 10'd1022, 10'd1023};
    logic [31:0]   load_data [8] = '{32'd11, 32'd22, 32'd33, 32'd44,
                                     32'h0000_00A0, 32'h0000_00A1,
                                     32'h0000_00A2, 32'h0000_00A3};

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every response must match the oldest expectation, in the
    // exact cycle; idle cycles must show all-zero data outputs.
    always @(negedge clock) begin
        if (inst_valid === 1'b1) begin
            chk("response_expected", 160'(sb.size() != 0), 160'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("rsp_cycle", 160'(mon_e.cyc), 160'(cyc));
                chk("rsp_rdata", 160'(inst_rdata), 160'(mon_e.rdata));
                chk("rsp_cnt_ex_code_unc",
                    160'({inst_count, inst_ex, inst_exccode, inst_uncache}),
                    160'({mon_e.count, mon_e.ex, mon_e.code, mon_e.unc}));
            end
        end else begin
            chk("idle_outputs_zero",
                160'({inst_valid, inst_rdata, inst_count, inst_ex, inst_exccode, inst_uncache}),
                160'd0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one request for one cycle; optionally record the response
    // the scoreboard should see LAT cycles later.
    task automatic fetch(input logic [31:0] a, input logic exp_ok, input logic push,
                         input logic [127:0] rd, input logic [1:0] cnt, input logic ex,
                         input logic [5:0] code, input logic unc);
        inst_req  = 1'b1;
        inst_addr = a;
        #1;
        chk("addr_ok", 160'(inst_addr_ok), 160'(exp_ok));
        if (push) sb.push_back('{cyc + int'(LAT), rd, cnt, ex, code, unc});
        step();
        inst_req  = 1'b0;
        inst_addr = '0;
    endtask

    task automatic ok(input logic [31:0] a, input logic [127:0] rd, input logic [1:0] cnt,
                      input logic ex, input logic [5:0] code, input logic unc);
        fetch(a, 1'b1, 1'b1, rd, cnt, ex, code, unc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step();
        // Load memory while in reset; requests must be refused meanwhile.
        inst_req  = 1'b1;
        inst_addr = 32'h0;
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = load_addr[i];
            wr_data = load_data[i];
            #1;
            chk("addr_ok_in_reset", 160'(inst_addr_ok), 160'd0);
            step();
        end
        wr_en    = 1'b0;
        inst_req = 1'b0;
        resetn   = 1'b1;
        step();

        // Full block, then back-to-back partial blocks.
        ok(32'h0, {32'd44, 32'd33, 32'd22, 32'd11}, 2'd3, 1'b0, 6'h0, 1'b0);
        idle(3);
        ok(32'h8, {64'd0, 32'd44, 32'd33}, 2'd1, 1'b0, 6'h0, 1'b0);
        ok(32'hC, {96'd0, 32'd44}, 2'd0, 1'b0, 6'h0, 1'b0);
        ok(32'h4, {32'd0, 32'd44, 32'd33, 32'd22}, 2'd2, 1'b0, 6'h0, 1'b0);

        // Exceptions, priority, uncached window, top-of-memory block.
        ok(32'h0000_0002, 128'd0, 2'd0, 1'b1, 6'h08, 1'b0);
        ok(32'h0001_0000, 128'd0, 2'd0, 1'b1, 6'h09, 1'b0);
        ok(32'h0000_1000, 128'd0, 2'd0, 1'b1, 6'h09, 1'b0);
        ok(32'hA000_0000, 128'd0, 2'd0, 1'b1, 6'h09, 1'b1);
        ok(32'hA000_0002, 128'd0, 2'd0, 1'b1, 6'h08, 1'b1);
        ok(32'h0000_0FF0, {32'h0A3, 32'h0A2, 32'h0A1, 32'h0A0}, 2'd3, 1'b0, 6'h0, 1'b0);
        ok(32'h0000_0FF8, {64'd0, 32'h0A3, 32'h0A2}, 2'd1, 1'b0, 6'h0, 1'b0);
        ok(32'h0000_0FFC, {96'd0, 32'h0A3}, 2'd0, 1'b0, 6'h0, 1'b0);
        idle(4);

        // Accept at t, cancel at t+1 (refused), new request at t+2 -> t+4.
        fetch(32'h0, 1'b1, 1'b0, 128'd0, 2'd0, 1'b0, 6'h0, 1'b0);
        inst_cancel = 1'b1;
        fetch(32'h4, 1'b0, 1'b0, 128'd0, 2'd0, 1'b0, 6'h0, 1'b0);
        inst_cancel = 1'b0;
        ok(32'h8, {64'd0, 32'd44, 32'd33}, 2'd1, 1'b0, 6'h0, 1'b0);
        idle(4);

        // Cancel in the very cycle the response would emerge.
        fetch(32'h0, 1'b1, 1'b0, 128'd0, 2'd0, 1'b0, 6'h0, 1'b0);
        step();
        inst_cancel = 1'b1;
        #1;
        chk("valid_during_cancel", 160'(inst_valid), 160'd0);
        step();
        inst_cancel = 1'b0;
        idle(3);

        // Stall blocks acceptance.
        mem_busy = 1'b1;
        fetch(32'h0, 1'b0, 1'b0, 128'd0, 2'd0, 1'b0, 6'h0, 1'b0);
        mem_busy = 1'b0;
        idle(3);

        // Write and read of the same word in one cycle: read sees old data.
        wr_en   = 1'b1;
        wr_addr = 10'd0;
        wr_data = 32'd55;
        ok(32'h0, {32'd44, 32'd33, 32'd22, 32'd11}, 2'd3, 1'b0, 6'h0, 1'b0);
        wr_en = 1'b0;
        step();
        ok(32'h0, {32'd44, 32'd33, 32'd22, 32'd55}, 2'd3, 1'b0, 6'h0, 1'b0);
        idle(4);

        // Reset between acceptance and response discards the fetch.
        fetch(32'h0, 1'b1, 1'b0, 128'd0, 2'd0, 1'b0, 6'h0, 1'b0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        idle(5);

        chk("scoreboard_drained", 160'(sb.size()), 160'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
